// File: rtl/fft_stage_param.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : fft_stage_param
//  Purpose  : One radix-2 decimation-in-time FFT stage with configurable
//             point count, butterfly span, sample/twiddle width and
//             butterfly parallelism. A complex frame is captured through a
//             valid/ready handshake. PAR butterfly units are time-multiplexed
//             over the frame. The result is held behind a second valid/ready
//             handshake.
//  Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Ports
//    clk_100MHz      in   clock, rising edge
//    rstn            in   asynchronous active-low reset
//    in_valid        in   input frame offered
//    in_ready        out  stage idle, frame can be accepted
//    in_re/in_im     in   input frame, element i at [i*DATA_W +: DATA_W]
//    tw_re/tw_im     in   twiddles W^k, k = 0..N_POINTS/2-1, Q2.(TW_W-2)
//    out_valid       out  result frame held
//    out_ready       in   downstream accepts the held frame
//    out_re/out_im   out  result frame, same packing as the input
//    sat             out  at least one output clipped in the held frame
//  Build option
//    FFT_STAGE_SCALE_EN : when defined, every output is halved (floor)
//                         before clipping and sat is held at 0.
// ============================================================================
module fft_stage_param #(
    parameter int DATA_W   = 16,
    parameter int TW_W     = 16,
    parameter int N_POINTS = 32,
    parameter int SPAN     = 4,
    parameter int PAR      = 4
) (
    input  logic                         clk_100MHz,
    input  logic                         rstn,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [N_POINTS*DATA_W-1:0]   in_re,
    input  logic [N_POINTS*DATA_W-1:0]   in_im,
    input  logic [(N_POINTS/2)*TW_W-1:0] tw_re,
    input  logic [(N_POINTS/2)*TW_W-1:0] tw_im,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [N_POINTS*DATA_W-1:0]   out_re,
    output logic [N_POINTS*DATA_W-1:0]   out_im,
    output logic                         sat
);

    localparam int C_HALF  = N_POINTS / 2;
    localparam int C_CYC   = N_POINTS / (2 * PAR);
    localparam int C_CNT_W = (C_CYC > 1) ? $clog2(C_CYC) : 1;
    localparam int C_IDX_W = $clog2(N_POINTS);
    localparam int C_K_W   = (C_HALF > 1) ? $clog2(C_HALF) : 1;
    localparam int C_KSTEP = N_POINTS / (2 * SPAN);
    localparam int C_PW    = DATA_W + TW_W + 1;   // full-precision complex product
    localparam int C_TW    = DATA_W + 2;          // rounded product t
    localparam int C_YW    = DATA_W + 3;          // butterfly sum/difference

    localparam logic [C_CNT_W-1:0]     C_LAST = C_CNT_W'(C_CYC - 1);
    localparam logic signed [C_PW-1:0] C_RND  = C_PW'(1) <<< (TW_W - 3);
    localparam logic signed [C_YW-1:0] C_MAX  = {4'b0000, {(DATA_W-1){1'b1}}};
    localparam logic signed [C_YW-1:0] C_MIN  = {4'b1111, {(DATA_W-1){1'b0}}};

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]               r_state;
    logic [1:0]               w_state_nxt;
    logic [C_CNT_W-1:0]       r_cnt;
    logic                     r_sat;
    logic                     w_accept;

    // Captured input frame and output register bank are separate, so the
    // butterflies never read a value already overwritten in this frame.
    logic signed [DATA_W-1:0] r_x_re [N_POINTS];
    logic signed [DATA_W-1:0] r_x_im [N_POINTS];
    logic signed [DATA_W-1:0] r_y_re [N_POINTS];
    logic signed [DATA_W-1:0] r_y_im [N_POINTS];

    logic signed [TW_W-1:0]   w_tw_re [C_HALF];
    logic signed [TW_W-1:0]   w_tw_im [C_HALF];

    logic [C_IDX_W-1:0]       w_a_idx [PAR];
    logic [C_IDX_W-1:0]       w_b_idx [PAR];
    logic signed [DATA_W-1:0] w_ya_re [PAR];
    logic signed [DATA_W-1:0] w_ya_im [PAR];
    logic signed [DATA_W-1:0] w_yb_re [PAR];
    logic signed [DATA_W-1:0] w_yb_im [PAR];
    logic [PAR-1:0]           w_sat_u;

    function automatic logic signed [DATA_W-1:0] f_clip(input logic signed [C_YW-1:0] v);
        logic signed [DATA_W-1:0] v_res;
        if (v > C_MAX)      v_res = C_MAX[DATA_W-1:0];
        else if (v < C_MIN) v_res = C_MIN[DATA_W-1:0];
        else                v_res = v[DATA_W-1:0];
        return v_res;
    endfunction

    function automatic logic f_ovf(input logic signed [C_YW-1:0] v);
        return (v > C_MAX) || (v < C_MIN);
    endfunction

    generate
        for (genvar k = 0; k < C_HALF; k++) begin : g_tw
            assign w_tw_re[k] = tw_re[k*TW_W +: TW_W];
            assign w_tw_im[k] = tw_im[k*TW_W +: TW_W];
        end

        for (genvar i = 0; i < N_POINTS; i++) begin : g_pack
            assign out_re[i*DATA_W +: DATA_W] = r_y_re[i];
            assign out_im[i*DATA_W +: DATA_W] = r_y_im[i];
        end

        for (genvar u = 0; u < PAR; u++) begin : g_bfly
            int                       w_j;
            int                       w_g;
            int                       w_p;
            logic [C_K_W-1:0]         w_k;
            logic signed [DATA_W-1:0] w_ar, w_ai, w_br, w_bi;
            logic signed [TW_W-1:0]   w_wr, w_wi;
            logic signed [C_PW-1:0]   w_pr, w_pi;
            logic signed [C_TW-1:0]   w_tr, w_ti;
            logic signed [C_YW-1:0]   w_sr, w_si, w_dr, w_di;

            // Butterfly j of the frame: group g, position p inside the group.
            always_comb begin
                w_j = int'(r_cnt) * PAR + u;
                w_g = w_j / SPAN;
                w_p = w_j % SPAN;
            end

            assign w_a_idx[u] = C_IDX_W'(2 * SPAN * w_g + w_p);
            assign w_b_idx[u] = C_IDX_W'(2 * SPAN * w_g + w_p + SPAN);
            assign w_k        = C_K_W'(w_p * C_KSTEP);

            assign w_ar = r_x_re[w_a_idx[u]];
            assign w_ai = r_x_im[w_a_idx[u]];
            assign w_br = r_x_re[w_b_idx[u]];
            assign w_bi = r_x_im[w_b_idx[u]];
            assign w_wr = w_tw_re[w_k];
            assign w_wi = w_tw_im[w_k];

            assign w_pr = C_PW'(w_br) * C_PW'(w_wr) - C_PW'(w_bi) * C_PW'(w_wi);
            assign w_pi = C_PW'(w_br) * C_PW'(w_wi) + C_PW'(w_bi) * C_PW'(w_wr);

            // Round half up back to sample scale, then keep DATA_W+2 bits.
            assign w_tr = C_TW'((w_pr + C_RND) >>> (TW_W - 2));
            assign w_ti = C_TW'((w_pi + C_RND) >>> (TW_W - 2));

            assign w_sr = C_YW'(w_ar) + C_YW'(w_tr);
            assign w_si = C_YW'(w_ai) + C_YW'(w_ti);
            assign w_dr = C_YW'(w_ar) - C_YW'(w_tr);
            assign w_di = C_YW'(w_ai) - C_YW'(w_ti);

`ifdef FFT_STAGE_SCALE_EN
            assign w_ya_re[u] = f_clip(w_sr >>> 1);
            assign w_ya_im[u] = f_clip(w_si >>> 1);
            assign w_yb_re[u] = f_clip(w_dr >>> 1);
            assign w_yb_im[u] = f_clip(w_di >>> 1);
            assign w_sat_u[u] = 1'b0;
`else
            assign w_ya_re[u] = f_clip(w_sr);
            assign w_ya_im[u] = f_clip(w_si);
            assign w_yb_re[u] = f_clip(w_dr);
            assign w_yb_im[u] = f_clip(w_di);
            assign w_sat_u[u] = f_ovf(w_sr) | f_ovf(w_si) | f_ovf(w_dr) | f_ovf(w_di);
`endif
        end
    endgenerate

    assign in_ready  = (r_state == S_IDLE);
    assign out_valid = (r_state == S_DONE);
    assign sat       = r_sat;
    assign w_accept  = (r_state == S_IDLE) && in_valid;

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (in_valid)          w_state_nxt = S_RUN;
            S_RUN:   if (r_cnt == C_LAST)   w_state_nxt = S_DONE;
            S_DONE:  if (out_ready)         w_state_nxt = S_IDLE;
            default:                        w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_100MHz or negedge rstn) begin
        if (!rstn) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_sat   <= 1'b0;
            for (int i = 0; i < N_POINTS; i++) begin
                r_x_re[i] <= '0;
                r_x_im[i] <= '0;
                r_y_re[i] <= '0;
                r_y_im[i] <= '0;
            end
        end else begin
            r_state <= w_state_nxt;
            if (w_accept) begin
                r_cnt <= '0;
                r_sat <= 1'b0;
                for (int i = 0; i < N_POINTS; i++) begin
                    r_x_re[i] <= in_re[i*DATA_W +: DATA_W];
                    r_x_im[i] <= in_im[i*DATA_W +: DATA_W];
                end
            end else if (r_state == S_RUN) begin
                r_cnt <= (r_cnt == C_LAST) ? '0 : r_cnt + 1'b1;
                r_sat <= r_sat | (|w_sat_u);
                for (int u = 0; u < PAR; u++) begin
                    r_y_re[w_a_idx[u]] <= w_ya_re[u];
                    r_y_im[w_a_idx[u]] <= w_ya_im[u];
                    r_y_re[w_b_idx[u]] <= w_yb_re[u];
                    r_y_im[w_b_idx[u]] <= w_yb_im[u];
                end
            end
        end
    end

endmodule
`default_nettype wire
